// File: rtl/power_if.sv
// Power-level bus: step/mode requests in, registered level out.
interface power_if;
    logic [1:0] powerUse;
    logic       powerMode;
    logic [7:0] powerOut;

    // Requester side: drives step and mode, observes the level
    modport master (
        output powerUse,
        output powerMode,
        input  powerOut
    );

    // Power block side: consumes step and mode, publishes the level
    modport slave (
        input  powerUse,
        input  powerMode,
        output powerOut
    );
endinterface

// File: rtl/power.sv
// Saturating power-level accumulator.
// Each clock the level moves by powerUse, down in drain mode and up in
// charge mode, clamping at MIN_LEVEL / MAX_LEVEL instead of wrapping.
module power #(
    parameter logic [7:0] MAX_LEVEL = 8'd255,
    parameter logic [7:0] MIN_LEVEL = 8'd0
) (
    input  logic    clk,
    input  logic    rst,
    power_if.slave  pwr
);

    logic       selDec;
    logic       limMin;
    logic       limMax;

    logic [8:0] sum_w;
    logic [8:0] diff_w;
    logic [8:0] floor_w;
    logic [8:0] head_w;

    logic [7:0] power_out_q;
    logic [7:0] power_out_d;

    assign selDec = ~pwr.powerMode;

    // 9-bit add/subtract; bit 8 is the carry (add) or borrow (subtract)
    assign sum_w  = {1'b0, power_out_q} + {7'b0, pwr.powerUse};
    assign diff_w = {1'b0, power_out_q} - {7'b0, pwr.powerUse};

    // A non-zero floor/ceiling is handled with a second borrow stage so the
    // limits always come from carry/borrow bits rather than magnitude compares.
    assign floor_w = {1'b0, diff_w[7:0]} - {1'b0, MIN_LEVEL};
    assign head_w  = {1'b0, MAX_LEVEL} - {1'b0, sum_w[7:0]};

    assign limMin = selDec  & (diff_w[8] | floor_w[8]);
    assign limMax = ~selDec & (sum_w[8]  | head_w[8]);

    // Next level: step in the selected direction, clamp on over/underflow
    always_comb begin
        power_out_d = power_out_q;
        if (selDec) begin
            power_out_d = limMin ? MIN_LEVEL : diff_w[7:0];
        end else begin
            power_out_d = limMax ? MAX_LEVEL : sum_w[7:0];
        end
    end

    // Level register; reset restores full charge and wins over any step
    always_ff @(posedge clk) begin
        if (rst) begin
            power_out_q <= MAX_LEVEL;
        end else begin
            power_out_q <= power_out_d;
        end
    end

    assign pwr.powerOut = power_out_q;

endmodule

// File: tb/tb_power.sv
// Scoreboard bench for the power accumulator: the driver pushes the
// hand-computed expected level and flags per vector, the monitor checks them.
module tb_power;

    logic clk;
    logic rst;

    power_if pif ();

    power dut (
        .clk (clk),
        .rst (rst),
        .pwr (pif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] exp_out;
        bit         chk_flags;
        logic       exp_sel;
        logic       exp_min;
        logic       exp_max;
        string      name;
    } vec_t;

    vec_t q_exp[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   drv_done = 1'b0;

    task automatic apply(input logic r, input logic mode, input logic [1:0] use_v,
                         input logic [7:0] exp_out, input bit chk,
                         input logic exp_min, input logic exp_max, input string name);
        vec_t v;
        @(negedge clk);
        rst           = r;
        pif.powerMode = mode;
        pif.powerUse  = use_v;
        v.exp_out   = exp_out;
        v.chk_flags = chk;
        v.exp_sel   = ~mode;
        v.exp_min   = exp_min;
        v.exp_max   = exp_max;
        v.name      = name;
        q_exp.push_back(v);
    endtask

    // Driver
    initial begin
        rst           = 1'b1;
        pif.powerMode = 1'b0;
        pif.powerUse  = 2'd3;

        // reset for two edges, level undefined before the first
        apply(1, 0, 3, 8'd255, 0, 0, 0, "reset1");
        apply(1, 0, 3, 8'd255, 1, 0, 0, "reset2");

        // drain 255 -> 65 by 1
        for (int i = 1; i <= 190; i++)
            apply(0, 0, 1, 8'(255 - i), 1, 0, 0, "drain");

        // charge 65 -> 255 by 1, exact landing at 255
        for (int i = 1; i <= 190; i++)
            apply(0, 1, 1, 8'(65 + i), 1, 0, 0, (i == 100) ? "charge165" : "charge");
        for (int i = 0; i < 3; i++)
            apply(0, 1, 1, 8'd255, 1, 0, 1, "ceil_hold");

        // drain to 4: 255 - 3*83 = 6, then 6 - 2 = 4
        for (int i = 1; i <= 83; i++)
            apply(0, 0, 3, 8'(255 - 3 * i), 1, 0, 0, "drain3");
        apply(0, 0, 2, 8'd4, 1, 0, 0, "to4");

        // floor
        apply(0, 0, 3, 8'd1, 1, 0, 0, "floor_4to1");
        apply(0, 0, 3, 8'd0, 1, 1, 0, "floor_1to0");
        apply(0, 0, 3, 8'd0, 1, 1, 0, "floor_hold");
        apply(0, 0, 3, 8'd0, 1, 1, 0, "floor_hold2");

        // hold with zero step in both modes
        apply(0, 0, 0, 8'd0, 1, 0, 0, "hold_drain");
        apply(0, 1, 0, 8'd0, 1, 0, 0, "hold_charge");

        // exact bound on the floor: 0 -> 3 -> 0
        apply(0, 1, 3, 8'd3, 1, 0, 0, "up_to3");
        apply(0, 0, 3, 8'd0, 1, 0, 0, "exact_3to0");

        // charge to 252, exact landing 252 + 3 = 255
        for (int i = 1; i <= 84; i++)
            apply(0, 1, 3, 8'(3 * i), 1, 0, 0, "charge3");
        apply(0, 1, 3, 8'd255, 1, 0, 0, "exact_252to255");
        apply(0, 1, 0, 8'd255, 1, 0, 0, "hold_max");

        // immediate mode switch, then drain 253 -> 100
        apply(0, 0, 2, 8'd253, 1, 0, 0, "mode_switch");
        for (int i = 1; i <= 51; i++)
            apply(0, 0, 3, 8'(253 - 3 * i), 1, 0, 0, "drain_to100");

        // mid-drain reset, then drain resumes
        apply(1, 0, 1, 8'd255, 1, 0, 0, "mid_reset");
        apply(0, 0, 1, 8'd254, 1, 0, 0, "after_reset");
        apply(0, 1, 2, 8'd255, 1, 0, 1, "charge_sat");

        drv_done = 1'b1;
    end

    // Monitor
    initial begin
        vec_t v;
        logic a_sel, a_min, a_max;
        while (!(drv_done && q_exp.size() == 0)) begin
            @(negedge clk);
            #2;
            if (q_exp.size() > 0) begin
                v     = q_exp.pop_front();
                a_sel = dut.selDec;
                a_min = dut.limMin;
                a_max = dut.limMax;
                if (v.chk_flags) begin
                    n_cmp++;
                    if ({a_sel, a_min, a_max} !== {v.exp_sel, v.exp_min, v.exp_max}) begin
                        n_err++;
                        $display("FAIL %s flags: selDec/limMin/limMax=%b%b%b expected %b%b%b",
                                 v.name, a_sel, a_min, a_max, v.exp_sel, v.exp_min, v.exp_max);
                    end
                end
                @(posedge clk);
                #1;
                n_cmp++;
                if (pif.powerOut !== v.exp_out) begin
                    n_err++;
                    $display("FAIL %s powerOut: got %0d expected %0d", v.name, pif.powerOut, v.exp_out);
                end
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #50000;
        n_err++;
        $display("FAIL timeout: run still active at %0t, expected done", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/power.md
POWER -- requirements
Module: power

Interface
REQ-001 The block SHALL have parameter MAX_LEVEL, default 8'd255: the full-charge level, which is also the reset value and the charge ceiling.
REQ-002 The block SHALL have parameter MIN_LEVEL, default 8'd0: the drain floor.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port powerUse, input, 2 bits: the unsigned step applied per cycle (0..3).
REQ-006 The block SHALL have port powerMode, input, 1 bit: 0 = drain (subtract), 1 = charge (add).
REQ-007 The block SHALL have port powerOut, output, 8 bits: the registered current power level, unsigned.
REQ-008 The block SHALL expose internal net selDec (1 bit), reachable hierarchically, equal to ~powerMode (1 = decrement path selected).
REQ-009 The block SHALL expose internal net limMin (1 bit), reachable hierarchically, asserted when selDec=1 and powerOut - powerUse would fall below MIN_LEVEL.
REQ-010 The block SHALL expose internal net limMax (1 bit), asserted when selDec=0 and powerOut + powerUse would exceed MAX_LEVEL.

Function
REQ-011 powerOut SHALL be a single 8-bit register updated only on the rising edge of clk.
REQ-012 With rst=0 and selDec=1, if limMin=0 the next powerOut SHALL be powerOut - powerUse.
REQ-013 With rst=0 and selDec=1, if limMin=1 the next powerOut SHALL be MIN_LEVEL: saturate, never wrap.
REQ-014 With rst=0 and selDec=0, if limMax=0 the next powerOut SHALL be powerOut + powerUse.
REQ-015 With rst=0 and selDec=0, if limMax=1 the next powerOut SHALL be MAX_LEVEL: saturate, never wrap.
REQ-016 powerUse=0 SHALL hold powerOut unchanged in either mode.
REQ-017 Latency SHALL be one cycle: input changes affect powerOut at the next rising edge, not combinationally.
REQ-018 selDec, limMin and limMax SHALL be combinational functions of the current powerOut, powerUse and powerMode.
REQ-019 The arithmetic SHALL use an 8-bit add/subtract with carry/borrow-out, and limMin/limMax SHALL be derived from that carry/borrow.
REQ-020 Exact landing on a bound (e.g. 3 - 3 = 0, 252 + 3 = 255) SHALL NOT assert limMin/limMax and SHALL produce the exact bound.
REQ-021 A mode change SHALL take effect on the next edge with no idle cycle.
REQ-022 powerOut at MIN_LEVEL in drain mode SHALL stay at MIN_LEVEL.
REQ-023 powerOut at MAX_LEVEL in charge mode SHALL stay at MAX_LEVEL.

Reset
REQ-024 When rst=1 at a rising edge, powerOut SHALL become MAX_LEVEL (255), regardless of powerUse and powerMode.
REQ-025 rst SHALL take priority over any add or subtract in the same cycle, including a reset asserted mid-drain or mid-charge.
REQ-026 Before the first reset edge powerOut is undefined; no requirement applies to it.
REQ-027 After rst deasserts, the first update SHALL occur on the next rising edge.

Verification
REQ-028 Reset: rst=1 for 2 edges with powerMode=0, powerUse=3 -> powerOut=255 after each edge.
REQ-029 Drain: from 255, powerMode=0, powerUse=1 for 190 edges -> powerOut=65; selDec=1, limMin=0 throughout.
REQ-030 Charge and saturation: from 65, powerMode=1, powerUse=1 -> 165 after 100 edges, 255 after 190 edges, then held at 255 with limMax=1.
REQ-031 Floor: from 4, powerMode=0, powerUse=3 -> 1, then 0 with limMin=1 at value 1, then held at 0.
REQ-032 Hold and exact bound: powerUse=0 in both modes -> no change; from 3 with powerUse=3 drain -> 0 with limMin=0 beforehand.
REQ-033 Mid-operation reset: reset while draining at level 100 -> 255 on that edge, then drain resumes next edge after rst=0 (254).
